// File: rtl/atomik_pkg.sv
// Shared definitions for the ATOMiK telemetry transmitter: packet framing
// constants, packet FSM encoding and baud divider calculation.
package atomik_pkg;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
    localparam int         PKT_BYTES         = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2
    } tx_state_t;

    // Cycles per UART bit; fractional part is dropped.
    function automatic int calc_bit_div(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/atomik_uart_tx_byte.sv
// UART 8N1 byte serialiser: start bit, 8 data bits LSB first, stop bit,
// each bit held for BIT_DIV cycles. done pulses on the final stop-bit cycle.
module atomik_uart_tx_byte
    import atomik_pkg::*;
#(
    parameter int BIT_DIV = 234
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       done,
    output logic       busy
);

    localparam int CW = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;

    logic [CW-1:0] baud_cnt;
    logic [3:0]    bit_cnt;
    logic [8:0]    shreg;
    logic          bit_end;

    assign bit_end = (baud_cnt == CW'(BIT_DIV - 1));
    assign done    = busy && bit_end && (bit_cnt == 4'd9);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx       <= 1'b1;
            busy     <= 1'b0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
        end else if (!busy) begin
            if (start) begin
                tx       <= 1'b0;
                busy     <= 1'b1;
                baud_cnt <= '0;
                bit_cnt  <= '0;
            end
        end else if (bit_end) begin
            baud_cnt <= '0;
            if (bit_cnt == 4'd9) begin
                busy <= 1'b0;
                tx   <= 1'b1;
            end else begin
                tx      <= shreg[0];
                bit_cnt <= bit_cnt + 4'd1;
            end
        end else begin
            baud_cnt <= baud_cnt + CW'(1);
        end
    end

    // Stop bit rides in the top of the shift register behind the data bits.
    always_ff @(posedge clk) begin
        if (!busy && start)
            shreg <= {1'b1, data};
        else if (busy && bit_end && (bit_cnt != 4'd9))
            shreg <= {1'b1, shreg[8:1]};
    end

endmodule

// File: rtl/atomik_telemetry_tx.sv
// Buffers ATOMiK core result words in a small FIFO and sends each one as a
// 6-byte packet (sync, 4 data bytes MSB-first, XOR checksum) over UART 8N1.
module atomik_telemetry_tx
    import atomik_pkg::*;
#(
    parameter int         CLK_FREQ   = 27_000_000,
    parameter int         BAUD_RATE  = 115200,
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEFAULT
) (
    input  logic                        sys_clk,
    input  logic                        sys_rst_n,
    input  logic [31:0]                 word_in,
    input  logic                        word_valid,
    input  logic                        enable,
    output logic                        uart_tx,
    output logic                        busy,
    output logic                        overflow,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    localparam int BIT_DIV = calc_bit_div(CLK_FREQ, BAUD_RATE);
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int LW      = AW + 1;

    function automatic logic [7:0] word_checksum(input logic [31:0] w);
        return w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
    endfunction

    logic [31:0]   fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          fifo_full, fifo_empty, push, pop;

    tx_state_t     state, state_nxt;
    logic [31:0]   pkt_sr;
    logic [7:0]    pkt_chk, cur_byte;
    logic [2:0]    byte_idx;
    logic          ser_start, ser_done, ser_busy;

    assign fifo_full  = (fifo_level == LW'(FIFO_DEPTH));
    assign fifo_empty = (fifo_level == '0);
    assign push       = word_valid && !fifo_full;
    assign pop        = (state == ST_LOAD);
    assign busy       = (state != ST_IDLE) || !fifo_empty || ser_busy;

    always_ff @(posedge sys_clk) begin
        if (push)
            fifo_mem[wr_ptr] <= word_in;
    end

    // A push against a full FIFO is dropped even when a pop frees a slot on the same edge.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (word_valid && fifo_full)
                overflow <= 1'b1;
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LW'(1);
                2'b01:   fifo_level <= fifo_level - LW'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cur_byte  = pkt_sr[31:24];
        case (state)
            ST_IDLE: if (enable && !fifo_empty) state_nxt = ST_LOAD;
            ST_LOAD: state_nxt = ST_SEND;
            ST_SEND: if (ser_done && (byte_idx == 3'(PKT_BYTES - 1))) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
        if (byte_idx == 3'd0)
            cur_byte = SYNC_BYTE;
        else if (byte_idx == 3'(PKT_BYTES - 1))
            cur_byte = pkt_chk;
    end

    // Start is registered so each byte begins one cycle after the previous done.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            ser_start <= 1'b0;
            byte_idx  <= '0;
        end else begin
            ser_start <= 1'b0;
            if (state == ST_LOAD) begin
                byte_idx  <= '0;
                ser_start <= 1'b1;
            end else if ((state == ST_SEND) && ser_done) begin
                byte_idx <= byte_idx + 3'd1;
                if (byte_idx != 3'(PKT_BYTES - 1))
                    ser_start <= 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (state == ST_LOAD) begin
            pkt_sr  <= fifo_mem[rd_ptr];
            pkt_chk <= word_checksum(fifo_mem[rd_ptr]);
        end else if ((state == ST_SEND) && ser_done && (byte_idx != 3'd0)) begin
            pkt_sr <= {pkt_sr[23:0], 8'h00};
        end
    end

    atomik_uart_tx_byte #(
        .BIT_DIV (BIT_DIV)
    ) u_uart_tx_byte (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .start (ser_start),
        .data  (cur_byte),
        .tx    (uart_tx),
        .done  (ser_done),
        .busy  (ser_busy)
    );

endmodule

// File: doc/atomik_telemetry_tx.md
Name: atomik_telemetry_tx

Overview:
- Downstream consumer of the ATOMiK core result stream.
- Captures each 32-bit core output word on its valid strobe and buffers it in a small FIFO.
- Frames each word as a 6-byte packet (sync, 4 data bytes MSB-first, XOR checksum) and serialises it as UART 8N1 on the board TX pin, replacing the bring-up loopback.

Parameters:
- CLK_FREQ, 27_000_000: sys_clk frequency in Hz.
- BAUD_RATE, 115200: line rate; BIT_DIV = CLK_FREQ/BAUD_RATE, truncated (234 at the default).
- FIFO_DEPTH, 4: word FIFO depth; power of 2, minimum 2.
- SYNC_BYTE, 8'hA5: first byte of every packet.

Ports:
- sys_clk  in  1  system clock.
- sys_rst_n  in  1  reset, asynchronous, active-low. Clock is sys_clk.
- word_in  in  32  core result word.
- word_valid  in  1  single-cycle push strobe; word_in is sampled on the same edge.
- enable  in  1  permission to start new packets.
- uart_tx  out  1  serial line; idles high.
- busy  out  1  high while a packet is in flight or the FIFO is non-empty.
- overflow  out  1  sticky flag; set when a push is dropped.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (asynchronous): uart_tx=1, busy=0, overflow=0, fifo_level=0, FSM=IDLE, FIFO pointers cleared. A reset mid-frame aborts the frame immediately; no partial byte resumes after release.
- FIFO push: word_valid=1 and not full → write and increment level.
- FIFO full: word_valid=1 and full → word dropped, overflow←1. overflow clears only on reset.
- Simultaneous push+pop when not full: level unchanged. Push while full is dropped even if a pop occurs on the same edge.
- Pointers wrap modulo FIFO_DEPTH; an extra level bit distinguishes full from empty.
- FSM IDLE: if enable=1 and FIFO non-empty → LOAD. If enable=0 → stay in IDLE; pushes are still accepted.
- FSM LOAD (1 cycle):
  - pop the head word into a shift register;
  - chk ← b3^b2^b1^b0;
  - byte_idx ← 0;
  - → SEND.
- FSM SEND: byte sequence is SYNC_BYTE, b3 (word_in[31:24]), b2, b1, b0, chk.
  - Pulse the serialiser start with the current byte.
  - On the serialiser done pulse: byte_idx+1. If byte_idx was 5 → IDLE, otherwise issue the next byte.
  - The next start bit begins exactly 1 cycle after done (no extra idle time between bytes).
- enable deasserted mid-packet: the current packet completes; no new packet starts.
- Latency: with IDLE, FIFO empty and enable=1, a word pushed at edge N is popped at edge N+2. The start bit (uart_tx=0) is driven from edge N+3.
- Serialiser line format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). Each bit lasts exactly BIT_DIV cycles, so one byte = 10×BIT_DIV cycles.
- Serialiser done: single-cycle pulse on the last cycle of the stop bit.
- Packet duration: 6×(10×BIT_DIV+1) cycles (14046 at the defaults).
- busy = (FSM≠IDLE) | (fifo_level≠0).

Decomposition:
- Shared package atomik_pkg: SYNC_BYTE default, PKT_BYTES=6, FSM state encoding (IDLE, LOAD, SEND), and the BIT_DIV computation function.
- One sub-module, atomik_uart_tx_byte:
  - inputs: clk, rst_n, start, data[7:0];
  - outputs: tx, done, busy;
  - contains the baud counter and bit counter.
- Word FIFO and packet FSM stay inline in atomik_telemetry_tx.

Test Plan:
- Single word: push 0x12345678 with enable=1.
  - uart_tx decodes to A5 12 34 56 78 08.
  - Start bit appears at push edge +3.
  - Every bit lasts 234 cycles.
  - busy falls after the final stop bit.
- Overflow: 6 pushes on consecutive edges 0..5, enable=1.
  - Edge 5 is dropped; overflow=1 from edge 5 onward.
  - Exactly 5 packets carrying words 0..4, in order.
  - fifo_level peaks at 4.
- Enable gating: enable=0, push 0xDEADBEEF and 0x00000001.
  - uart_tx stays 1, fifo_level=2, busy=1.
  - Raise enable → packets A5 DE AD BE EF 22, then A5 00 00 00 01 01.
- Enable drop mid-packet: clear enable during byte 2 with 1 word queued.
  - Current packet completes all 6 bytes.
  - Queued word is not sent until enable=1.
- Reset mid-frame: assert sys_rst_n=0 during byte 3.
  - uart_tx=1, overflow=0, fifo_level=0 asynchronously.
  - After release, a fresh push yields a complete, correct packet.
- Push/pop collision: FIFO at 3 of 4, push coincides with the LOAD pop edge.
  - fifo_level stays 3, no overflow.
  - Data order is preserved across all packets.
